// File: rtl/seq_alu_if.sv
// Request/response bundle between a control source and the seq_alu execution unit.
// The master issues operations and consumes results; the slave (seq_alu) serves them.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             illegal_op;

    modport master (
        output in_valid, SrcA, SrcB, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, illegal_op
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, Zero, illegal_op
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, one-bit-per-cycle shifts,
// valid/ready handshakes on both the request and the result side.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    seq_alu_if.slave   bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [4:0]       cnt_r, cnt_s;
    logic [3:0]       op_r, op_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             illegal_r, illegal_s;
    logic [WIDTH-1:0] shifted_s;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op >= 4'b1010;
    endfunction

    // One-bit step of the iterative shifter; SRA replicates the sign bit.
    function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Single-cycle result; shifts only reach here with a zero shift amount.
    function automatic logic [WIDTH-1:0] compute(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL,
            OP_SRL,
            OP_SRA:  r = a;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    assign shifted_s = shift1(op_r, acc_r);

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        op_s      = op_r;
        result_s  = result_r;
        illegal_s = illegal_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    op_s  = bus.ALUControl;
                    acc_s = bus.SrcA;
                    cnt_s = bus.SrcB[4:0];
                    if (is_shift(bus.ALUControl) && (bus.SrcB[4:0] != 5'd0)) begin
                        state_s = SHIFT;
                    end else begin
                        result_s  = compute(bus.ALUControl, bus.SrcA, bus.SrcB);
                        illegal_s = is_illegal(bus.ALUControl);
                        state_s   = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                acc_s = shifted_s;
                cnt_s = cnt_r - 5'd1;
                if (cnt_r == 5'd1) begin
                    result_s  = shifted_s;
                    illegal_s = 1'b0;
                    state_s   = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            acc_r     <= {WIDTH{1'b0}};
            cnt_r     <= 5'd0;
            op_r      <= 4'd0;
            result_r  <= {WIDTH{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            cnt_r     <= cnt_s;
            op_r      <= op_s;
            result_r  <= result_s;
            illegal_r <= illegal_s;
        end
    end

    assign bus.in_ready   = (state_r == IDLE);
    assign bus.out_valid  = (state_r == DONE);
    assign bus.ALUResult  = result_r;
    assign bus.Zero       = (result_r == {WIDTH{1'b0}});
    assign bus.illegal_op = illegal_r;
endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu with hand-written backpressure,
// mid-operation reset and illegal-code sequences.
module tb_seq_alu;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the result, return latency and sample outputs.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.SrcA       = $urandom;
        bus.SrcB       = $urandom;
        bus.ALUControl = 4'($urandom_range(0, 9));
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (bus.in_ready) busy_ok = 1'b0;
    endtask

    int   lat;
    logic busy_ok;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{"add_ovf",  4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1};
        vecs[1]  = '{"sub_zero", 4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1};
        vecs[2]  = '{"slt",      4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1};
        vecs[3]  = '{"sltu",     4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1};
        vecs[4]  = '{"xor",      4'b0100, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0, 1};
        vecs[5]  = '{"or",       4'b0011, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1};
        vecs[6]  = '{"sra31",    4'b1000, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 32};
        vecs[7]  = '{"sll_sh0",  4'b0110, 32'h00000001, 32'h00000020, 32'h00000001, 1'b0, 1};
        vecs[8]  = '{"srl4",     4'b0111, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 5};
        vecs[9]  = '{"sll3",     4'b0110, 32'h00000001, 32'h00000003, 32'h00000008, 1'b0, 4};
        vecs[10] = '{"sra_pos",  4'b1000, 32'h40000000, 32'h00000002, 32'h10000000, 1'b0, 3};
        vecs[11] = '{"ill_1111", 4'b1111, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1};
        vecs[12] = '{"add_clr",  4'b0000, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1};
        vecs[13] = '{"ill_1010", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1};
        vecs[14] = '{"srl_clr",  4'b0111, 32'h000000F0, 32'h00000004, 32'h0000000F, 1'b0, 5};
        vecs[15] = '{"slt_neg",  4'b0101, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 1};

        // Reset with random inputs.
        reset          = 1'b1;
        bus.in_valid   = 1'($urandom);
        bus.SrcA       = $urandom;
        bus.SrcB       = $urandom;
        bus.ALUControl = 4'($urandom);
        bus.out_ready  = 1'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, bus.in_ready},   32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid},  32'd0);
        chk("rst_result",    bus.ALUResult,           32'd0);
        chk("rst_zero",      {31'd0, bus.Zero},       32'd1);
        chk("rst_illegal",   {31'd0, bus.illegal_op}, 32'd0);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_ok);
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].name, "_result"},  bus.ALUResult, vecs[i].exp_res);
            chk({vecs[i].name, "_zero"},    {31'd0, bus.Zero}, {31'd0, (vecs[i].exp_res == 32'd0)});
            chk({vecs[i].name, "_illegal"}, {31'd0, bus.illegal_op}, {31'd0, vecs[i].exp_ill});
            chk({vecs[i].name, "_busy"},    {31'd0, busy_ok}, 32'd1);
            @(negedge clk);
            chk({vecs[i].name, "_idle"},    {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        end

        // Backpressure: hold result, ignore a request presented during the stall.
        bus.out_ready = 1'b0;
        run_op(4'b0010, 32'h000000FF, 32'h0000000F, lat, busy_ok);
        chk("bp_latency", 32'(lat), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_result", bus.ALUResult, 32'h0000000F);
            chk("bp_hold_flags",  {29'd0, bus.out_valid, bus.in_ready, bus.Zero}, 32'd4);
            bus.in_valid   = (c == 2);
            bus.ALUControl = 4'b0000;
            bus.SrcA       = 32'h00001000;
            bus.SrcB       = 32'h00000001;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle",        {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        chk("bp_result_kept", bus.ALUResult, 32'h0000000F);
        @(negedge clk);
        chk("bp_no_ghost",    {30'd0, bus.in_ready, bus.out_valid}, 32'd2);

        // Reset in cycle 10 of a 20-step shift abandons it.
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.ALUControl = 4'b0111;
        bus.SrcA       = 32'hFFFFFFFF;
        bus.SrcB       = 32'd20;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_ready", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        chk("mid_rst_result", bus.ALUResult, 32'd0);
        busy_ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) busy_ok = 1'b0;
        end
        chk("mid_no_out_valid", {31'd0, busy_ok}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle execution unit consuming the 4-bit ALUControl encoding produced by the ALU decoder. It is the sink end of that control interface for the planned multi-cycle core variant. Operands and control are captured under a valid/ready handshake. Shifts run iteratively, one bit per cycle, and all other operations complete in one cycle. The result is held under an output valid/ready handshake until consumed.

## Interface
Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; shift amounts are 5 bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid; operands and control are sampled when in_valid && in_ready.
- in_ready  out  1  unit is idle and can accept a request.
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B; only SrcB[4:0] is used for shifts.
- ALUControl  in  4  operation code (see Operation).
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- ALUResult  out  WIDTH  registered result.
- Zero  out  1  (ALUResult == 0); combinational from the result register.
- illegal_op  out  1  registered; set together with a result when the code was unsupported.

## Operation
- ALUControl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 1001 SLTU (unsigned); result is 32'h0 or 32'h1.
  - 0110 SLL, 0111 SRL, 1000 SRA.
  - 1010–1111 are illegal.
- ADD/SUB wrap modulo 2^32; no overflow flag.
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE, on accept:
  - SrcA, shamt = SrcB[4:0] and the code are captured.
  - Non-shift op, or shift with shamt == 0: the result is computed and written, then go to DONE. For a shift with shamt == 0 the result is SrcA.
  - Illegal code: ALUResult = 0 and illegal_op = 1, then go to DONE.
  - Shift with shamt ≥ 1: acc = SrcA, cnt = shamt, go to SHIFT.
- SHIFT, every cycle:
  - acc is shifted by 1 bit. SLL fills 0 into bit 0; SRL fills 0 into bit 31; SRA fills with acc[31].
  - cnt is decremented.
  - When cnt == 1 before the decrement, the shifted value is written to ALUResult and the state goes to DONE.
- DONE: ALUResult, Zero and illegal_op are held stable. On out_ready, go to IDLE.
- illegal_op is cleared on every legal completion.
- Requests presented while in_ready = 0 are ignored; they are neither queued nor sampled.
- Inputs changing after the accept cycle have no effect on an operation in flight.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - ALUResult = 0, Zero = 1, illegal_op = 0.
  - acc = 0, cnt = 0.
- Reset has priority over every other event. Asserted mid-SHIFT or in DONE, the operation is abandoned: IDLE at the next edge and no out_valid for that request.
- Latency, measured from the accept cycle (cycle 0) to the first cycle with out_valid = 1:
  - Non-shift, illegal, or shamt == 0: 1 cycle.
  - Shift with shamt ≥ 1: shamt + 1 cycles (maximum 32).
- Throughput: at most one operation in flight; in_ready is low from cycle 1 until the cycle after the output handshake.
- out_valid, once high, stays high with a stable result until out_ready is sampled high.
- The output handshake returns the unit to IDLE, so in_ready = 1 in the following cycle. A new request can be accepted no earlier than that cycle.
- A 0-cycle out_ready stall is allowed: out_ready may be held high permanently, giving an out_valid pulse of exactly 1 cycle.

## Test plan
- Reset:
  - Stimulus: hold reset 2 cycles with random inputs.
  - Required: in_ready = 1, out_valid = 0, ALUResult = 0, Zero = 1, illegal_op = 0.
- ADD / SUB:
  - Stimulus: ADD 0x7FFFFFFF + 0x00000001, then SUB 0x5 − 0x5.
  - Required: 0x80000000 with Zero = 0, out_valid 1 cycle after accept; then 0x0 with Zero = 1.
- Compares:
  - Stimulus: SLT with 0xFFFFFFFF vs 0x1; SLTU with the same operands; XOR 0xF0F0F0F0 ^ 0xFFFF0000.
  - Required: 0x1; 0x0; 0x0F0FF0F0.
- Shifts:
  - Stimulus: SRA 0x80000000 by SrcB = 31.
  - Required: 0xFFFFFFFF, out_valid 32 cycles after accept, in_ready low throughout.
  - Stimulus: SLL 0x1 with SrcB = 0x20 (shamt 0).
  - Required: 0x1 after 1 cycle.
  - Stimulus: SRL 0x80000000 by 4.
  - Required: 0x08000000 after 5 cycles.
- Backpressure:
  - Stimulus: complete AND 0xFF & 0x0F while out_ready is held low for 5 cycles; pulse in_valid with a new op during the stall.
  - Required: result 0x0F held stable for 5 cycles; in_ready = 0; the new op is ignored; IDLE the cycle after out_ready rises.
- Reset mid-operation and illegal code:
  - Stimulus: SRL 0xFFFFFFFF by 20, reset asserted in cycle 10.
  - Required: in_ready = 1 next cycle; out_valid never asserts for that op.
  - Stimulus: ALUControl = 1111.
  - Required: ALUResult = 0, Zero = 1, illegal_op = 1 after 1 cycle; illegal_op = 0 after the next legal op.
